// File: rtl/md_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encoding,
// FSM state type and a constant-width helper.
package md_pkg;

   localparam int MD_OP_W = 7;
   localparam int MD_MUL  = 0;
   localparam int MD_MULH = 1;
   localparam int MD_MULHU = 2;
   localparam int MD_DIV  = 3;
   localparam int MD_MOD  = 4;
   localparam int MD_DIVU = 5;
   localparam int MD_MODU = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division step, selected by i_div.
module md_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;

   assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
   assign w_shift = {i_hi, i_lo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, i_b};

   // The remainder stays below the divisor, so both candidates fit in WIDTH bits.
   always_comb begin
      if (i_div) begin
         o_hi = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
         o_lo = {i_lo[WIDTH-2:0], ~w_trial[WIDTH]};
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one operation per handshake, WIDTH
// iteration cycles, a sign-fix cycle, then the result is held until consumed.
module mul_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result
);

   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   md_state_t          r_state;
   md_state_t          w_state_next;
   logic [CW-1:0]      r_cnt;
   logic [MD_OP_W-1:0] r_op;
   logic               r_op_ok, r_div, r_s1, r_s2, r_bz, r_in_ready;
   logic [WIDTH-1:0]   r_hi, r_lo, r_b, r_result;

   logic               w_accept, w_signed, w_div_op, w_onehot, w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_step_hi, w_step_lo;
   logic [WIDTH-1:0]   w_quot, w_rem, w_fix;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;

   assign w_accept = in_valid && r_in_ready && !flush && (r_state == IDLE);
   assign w_signed = md_op[MD_MUL] | md_op[MD_MULH] | md_op[MD_DIV] | md_op[MD_MOD];
   assign w_div_op = md_op[MD_DIV] | md_op[MD_MOD] | md_op[MD_DIVU] | md_op[MD_MODU];
   assign w_onehot = (md_op != '0) && ((md_op & (md_op - MD_OP_W'(1))) == '0);
   assign w_a_neg  = w_signed & src1[WIDTH-1];
   assign w_b_neg  = w_signed & src2[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -src1 : src1;
   assign w_b_mag  = w_b_neg ? -src2 : src2;

   md_step #(.WIDTH(WIDTH)) u_step (
      .i_div (r_div),
      .i_hi  (r_hi),
      .i_lo  (r_lo),
      .i_b   (r_b),
      .o_hi  (w_step_hi),
      .o_lo  (w_step_lo)
   );

   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_accept) w_state_next = BUSY;
            BUSY:    if (r_cnt == '0) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   // Divide by zero must yield all-ones even when the dividend sign would flip it.
   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = (r_s1 ^ r_s2) ? -w_prod : w_prod;
   assign w_quot   = r_bz ? '1 : ((r_s1 ^ r_s2) ? -r_lo : r_lo);
   assign w_rem    = r_s1 ? -r_hi : r_hi;

   always_comb begin
      w_fix = '0;
      if (r_op_ok) begin
         if (r_op[MD_MUL])                        w_fix = w_prod_s[WIDTH-1:0];
         else if (r_op[MD_MULH] | r_op[MD_MULHU]) w_fix = w_prod_s[2*WIDTH-1:WIDTH];
         else if (r_op[MD_DIV] | r_op[MD_DIVU])   w_fix = w_quot;
         else if (r_op[MD_MOD] | r_op[MD_MODU])   w_fix = w_rem;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_in_ready <= 1'b0;
         r_result   <= '0;
         r_op       <= '0;
         r_op_ok    <= 1'b0;
         r_div      <= 1'b0;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_bz       <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_b        <= '0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next == IDLE);
         if (flush) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_op    <= md_op;
            r_op_ok <= w_onehot;
            r_div   <= w_div_op;
            r_s1    <= w_a_neg;
            r_s2    <= w_b_neg;
            r_bz    <= (src2 == '0);
            r_hi    <= '0;
            r_lo    <= w_div_op ? w_a_mag : w_b_mag;
            r_b     <= w_div_op ? w_b_mag : w_a_mag;
         end else if (r_state == BUSY) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         end
         if (r_state == FIX && !flush) r_result <= w_fix;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state == DONE);
   assign result    = r_result;

endmodule
